timer_wait_scheduler: RTL and testbench
=======================================

// Module: timer_wait_scheduler
// PURPOSE
//  Shares one wait-counter resource (start / wait-count / done contract) among NUM_REQ requesters in the UART block.
//  Round-robin arbitration; sequences the timer: drives start level + wait count, collects done, returns a per-requester done pulse.
//  Sits between UART TX/RX sequencers (bit-gap, break, inter-frame waits) and the shared timer.
// PARAMETERS
//  NUM_REQ   4              number of requesters (2..8)
//  WAIT_W    32             width of wait counts
//  MAX_WAIT  32'd100000000  largest legal wait (1 s at 100 MHz); larger requests rejected
//  WD_SLACK  32'd16         extra cycles beyond the granted wait before watchdog fires (TIMER_WATCHDOG_EN only)
// PORTS
//  clk        in   1               system clock, 100 MHz
//  rst_n      in   1               asynchronous reset, active low
//  req        in   NUM_REQ         level request per requester; held until its done/err pulse
//  req_wait   in   NUM_REQ*WAIT_W  wait count per requester, slice i = [i*WAIT_W +: WAIT_W]; stable while req[i]=1
//  grant      out  NUM_REQ         one-hot, the requester currently owning the timer
//  done       out  NUM_REQ         1-cycle pulse: wait of requester i finished
//  err        out  NUM_REQ         1-cycle pulse: request i rejected or watchdog expired
//  busy       out  1               FSM not in IDLE
//  tmr_start  out  1               timer start level; high for the whole RUN state
//  tmr_wait   out  WAIT_W          latched wait count of granted requester
//  tmr_done   in   1               timer completion pulse
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
//  All outputs registered. FSM states: IDLE, RUN, GAP.
//  IDLE: winner = first set req bit searching from pointer+1, wrapping modulo NUM_REQ. No req set: stay IDLE.
//   winner wait == 0: done[w] pulses next cycle; no grant; tmr_start stays 0; pointer = w; stay IDLE.
//   winner wait > MAX_WAIT: err[w] pulses next cycle; no grant; pointer = w; stay IDLE.
//   else: next cycle grant[w]=1, tmr_start=1, tmr_wait=wait; pointer = w; -> RUN.
//  RUN: on tmr_done=1, next cycle done[w]=1 for 1 cycle, grant=0, tmr_start=0 -> GAP.
//  GAP: exactly one cycle with tmr_start low so the timer re-arms -> IDLE.
//   Minimum spacing between successive grants is therefore 2 cycles after done.
//  tmr_done outside RUN: ignored.
//  req[w] dropped during RUN: service still completes; done[w] still pulses. The requester ignores it.
//  req[i] rising while busy: not lost; served on a later IDLE arbitration (level-held contract).
//  At most one bit set in done|err per cycle; done and err never both set.
//  rst_n low mid-RUN: immediate return to reset values; tmr_start drops asynchronously.
//  Bits of req_wait are compared unsigned; tmr_wait is never updated outside the IDLE->RUN transition.
// CONFIGURATION
//  TIMER_WATCHDOG_EN defined: WAIT_W-bit watchdog counter cleared on entry to RUN, incremented each RUN cycle.
//   When it reaches tmr_wait+WD_SLACK with no tmr_done: err[w] pulses (no done), grant/tmr_start drop -> GAP.
//   Sum is computed at WAIT_W+1 bits, so it cannot wrap.
//  TIMER_WATCHDOG_EN undefined: no watchdog logic; RUN waits indefinitely for tmr_done; err only from MAX_WAIT rejection.
// STRUCTURE
//  Package uart_timer_pkg: FSM state localparams (IDLE=2'd0, RUN=2'd1, GAP=2'd2), default MAX_WAIT and WD_SLACK constants.
//  One sub-module, rr_arbiter: req vector + pointer in -> one-hot winner + index out. Combinational; pointer register stays in this block.
//  The FSM, latches and watchdog stay in this block.
// TESTING
//  1. Reset, then req=4'b0001, wait0=5, tmr_done pulsed 6 cycles after tmr_start -> grant=0001, tmr_wait=5; done[0] 1 cycle after tmr_done; tmr_start low 1 cycle before next grant.
//  2. req=4'b1011 held, all waits=3 -> services in order 0,1,3,0,... with no requester starved; grants non-overlapping.
//  3. wait1=0 -> done[1] pulses 1 cycle after arbitration; tmr_start never rises. wait2=32'd100000001 -> err[2] pulses, no grant.
//  4. tmr_done pulsed while IDLE and during GAP -> no done/err pulse, no state change.
//  5. rst_n asserted mid-RUN (wait=1000, cycle 400) -> grant/tmr_start/busy 0 immediately; after release, requester 0 is served first.
//  6. TIMER_WATCHDOG_EN defined, wait=20, tmr_done never arrives -> err[w] at RUN cycle 36 (20+16), then GAP, then IDLE; undefined -> stays in RUN.

Source files
------------

// File: rtl/timer_wait_scheduler_pkg.sv
// Shared types and defaults for the UART timer wait scheduler: FSM state
// encoding plus default wait limit and watchdog slack.
package uart_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_MAX_WAIT = 32'd100000000;
  localparam logic [31:0] DEF_WD_SLACK = 32'd16;

endpackage

// File: rtl/timer_wait_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping modulo NUM_REQ. Pointer storage lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  int j;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    win_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/timer_wait_scheduler.sv
// Shares one wait timer among NUM_REQ requesters with round-robin arbitration.
// Optional watchdog on the RUN state is enabled by defining TIMER_WATCHDOG_EN.
module timer_wait_scheduler
  import uart_timer_pkg::*;
#(
  parameter int                NUM_REQ  = 4,
  parameter int                WAIT_W   = 32,
  parameter logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(DEF_MAX_WAIT)
`ifdef TIMER_WATCHDOG_EN
  , parameter logic [WAIT_W-1:0] WD_SLACK = WAIT_W'(DEF_WD_SLACK)
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WAIT_W-1:0] req_wait,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      tmr_start,
  output logic [WAIT_W-1:0]         tmr_wait,
  input  logic                      tmr_done
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0]  grant_q, done_q, err_q;
  logic                busy_q, tmr_start_q;
  logic [WAIT_W-1:0]   tmr_wait_q;

  logic [NUM_REQ-1:0]  arb_req, arb_win;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [WAIT_W-1:0]   win_wait;

  // A requester answered this cycle still holds req until it sees the pulse.
  assign arb_req = req & ~(done_q | err_q);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .win_o   (arb_win),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    win_wait = req_wait[int'(arb_idx)*WAIT_W +: WAIT_W];
  end

`ifdef TIMER_WATCHDOG_EN
  logic [WAIT_W-1:0] wd_cnt_q;
  logic              wd_hit;
  // Compared one bit wider so wait + slack cannot wrap.
  assign wd_hit = ({1'b0, wd_cnt_q} + (WAIT_W+1)'(1)) ==
                  ({1'b0, tmr_wait_q} + {1'b0, WD_SLACK});
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_W'(NUM_REQ-1);
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      tmr_start_q <= 1'b0;
      tmr_wait_q  <= '0;
`ifdef TIMER_WATCHDOG_EN
      wd_cnt_q    <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            ptr_q <= arb_idx;
            if (win_wait == '0) begin
              done_q <= arb_win;
            end else if (win_wait > MAX_WAIT) begin
              err_q <= arb_win;
            end else begin
              grant_q     <= arb_win;
              tmr_start_q <= 1'b1;
              tmr_wait_q  <= win_wait;
              busy_q      <= 1'b1;
              state_q     <= RUN;
`ifdef TIMER_WATCHDOG_EN
              wd_cnt_q    <= '0;
`endif
            end
          end
        end
        RUN: begin
          if (tmr_done) begin
            done_q      <= grant_q;
            grant_q     <= '0;
            tmr_start_q <= 1'b0;
            state_q     <= GAP;
          end
`ifdef TIMER_WATCHDOG_EN
          else if (wd_hit) begin
            err_q       <= grant_q;
            grant_q     <= '0;
            tmr_start_q <= 1'b0;
            state_q     <= GAP;
          end else begin
            wd_cnt_q <= wd_cnt_q + WAIT_W'(1);
          end
`endif
        end
        GAP: begin
          // One idle cycle with tmr_start low lets the timer re-arm.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign tmr_start = tmr_start_q;
  assign tmr_wait  = tmr_wait_q;

endmodule

// File: tb/tb_timer_wait_scheduler.sv
// Self-checking bench for timer_wait_scheduler: the bench plays requesters and
// the shared timer, predicting service order and exact event cycles.
module tb_timer_wait_scheduler;

  localparam int          N    = 4;
  localparam int          W    = 32;
  localparam logic [31:0] MAXW = 32'd100000000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*W-1:0]    req_wait;
  logic [N-1:0]      grant, done, err;
  logic              busy, tmr_start, tmr_done;
  logic [W-1:0]      tmr_wait;

  int                ntests = 0;
  int                nfail  = 0;
  int                ptr_m;
  logic [W-1:0]      wv [N];

  timer_wait_scheduler #(.NUM_REQ(N), .WAIT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_wait  (req_wait),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .tmr_start (tmr_start),
    .tmr_wait  (tmr_wait),
    .tmr_done  (tmr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, end any timer pulse, check invariants.
  task automatic tick();
    @(negedge clk);
    tmr_done = 1'b0;
    check("inv_done_and_err", 64'(done & err), 64'(0));
    check("inv_onehot", {62'd0, $onehot0(done | err), $onehot0(grant)}, 64'd3);
    check("inv_start_grant", 64'(tmr_start), 64'(|grant));
  endtask

  function automatic int rr_pick(input logic [N-1:0] pm, input int p);
    for (int k = 1; k <= N; k++) begin
      if (pm[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // 0: zero wait, 1: timed wait, 2: rejected
  function automatic int kind(input logic [W-1:0] w);
    if (w == '0) return 0;
    if (w > MAXW) return 2;
    return 1;
  endfunction

  task automatic run_round(input logic [N-1:0] set, input logic [N-1:0] late,
                           input int dmin, input int dmax, input bit gap_poke);
    logic [N-1:0] pm, oh;
    int           w, delay, d;
    bit           late_done;
    for (int i = 0; i < N; i++) req_wait[i*W +: W] = wv[i];
    req       = set;
    pm        = set;
    late_done = (late == '0);
    delay     = 1;
    while (pm != '0) begin
      w  = rr_pick(pm, ptr_m);
      oh = N'(1) << w;
      for (int k = 1; k < delay; k++) begin
        tick();
        check("quiet_between", 64'({grant, done, err}), 64'(0));
      end
      tick();
      case (kind(wv[w]))
        0: begin
          check("zero_wait_done", 64'({grant, done, err, tmr_start}),
                64'({{N{1'b0}}, oh, {N{1'b0}}, 1'b0}));
          delay = 1;
        end
        2: begin
          check("reject_err", 64'({grant, done, err, tmr_start}),
                64'({{N{1'b0}}, {N{1'b0}}, oh, 1'b0}));
          delay = 1;
        end
        default: begin
          check("grant", 64'({grant, done, err, tmr_start, busy}),
                64'({oh, {N{1'b0}}, {N{1'b0}}, 2'b11}));
          check("tmr_wait", 64'(tmr_wait), 64'(wv[w]));
          if (!late_done) begin
            req       = req | late;
            pm        = pm | late;
            late_done = 1'b1;
          end
          d = $urandom_range(dmax, dmin);
          for (int k = 1; k < d; k++) begin
            tick();
            check("grant_held", 64'({grant, done, tmr_start}), 64'({oh, {N{1'b0}}, 1'b1}));
          end
          tmr_done = 1'b1;
          tick();
          check("run_done", 64'({grant, done, err, tmr_start, busy}),
                64'({{N{1'b0}}, oh, {N{1'b0}}, 2'b01}));
          if (gap_poke) tmr_done = 1'b1;
          delay = 2;
        end
      endcase
      req[w] = 1'b0;
      pm[w]  = 1'b0;
      ptr_m  = w;
    end
    tick();
    check("round_idle", 64'({grant, done, err, busy, tmr_start}), 64'(0));
    tick();
    check("round_quiet", 64'({grant, done, err, busy}), 64'(0));
  endtask

  initial begin
    logic [N-1:0] set;
    int           r;
    req      = '0;
    req_wait = '0;
    tmr_done = 1'b0;
    rst_n    = 1'b1;
    ptr_m    = N - 1;
    for (int i = 0; i < N; i++) wv[i] = '0;

    // Reset state
    #3 rst_n = 1'b0;
    #1 check("reset_outputs", 64'({grant, done, err, busy, tmr_start}), 64'(0));
    check("reset_tmr_wait", 64'(tmr_wait), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester, wait 5, timer completes after 6 cycles
    wv[0] = 32'd5;
    run_round(4'b0001, 4'b0000, 6, 6, 1'b0);

    // Three requesters held with equal waits, repeated rounds
    for (int k = 0; k < 3; k++) begin
      wv[0] = 32'd3; wv[1] = 32'd3; wv[3] = 32'd3;
      run_round(4'b1011, 4'b0000, 1, 4, 1'b0);
    end

    // Zero wait and over-limit rejection mixed with a timed wait
    wv[0] = 32'd7; wv[1] = 32'd0; wv[2] = 32'd100000001;
    run_round(4'b0111, 4'b0000, 2, 3, 1'b0);

    // Exact limit accepted, one above rejected, minimum wait accepted
    wv[0] = MAXW; wv[1] = 32'd1; wv[3] = MAXW + 32'd1;
    run_round(4'b1011, 4'b0000, 1, 2, 1'b0);

    // Stray timer pulses while idle and during the gap cycle
    tmr_done = 1'b1;
    tick();
    check("idle_poke", 64'({grant, done, err, busy, tmr_start}), 64'(0));
    tick();
    check("idle_poke_after", 64'({grant, done, err, busy}), 64'(0));
    wv[2] = 32'd4; wv[3] = 32'd2;
    run_round(4'b1100, 4'b0000, 2, 4, 1'b1);

    // Request raised while another is being served is served afterwards
    wv[1] = 32'd5; wv[3] = 32'd2;
    run_round(4'b0010, 4'b1000, 3, 3, 1'b0);

    // Reset in the middle of a long wait
    wv[2] = 32'd1000;
    req_wait[2*W +: W] = wv[2];
    req = 4'b0100;
    tick();
    check("rst_pre_grant", 64'({grant, tmr_wait}), 64'({4'b0100, 32'd1000}));
    for (int k = 0; k < 400; k++) tick();
    #2 rst_n = 1'b0;
    #1 check("rst_mid_run", 64'({grant, tmr_start, busy}), 64'(0));
    req = '0;
    tick();
    rst_n = 1'b1;
    ptr_m = N - 1;
    wv[0] = 32'd3; wv[2] = 32'd3;
    run_round(4'b0101, 4'b0000, 1, 3, 1'b0);

    // Timer never answers a wait of 20
    wv[1] = 32'd20;
    req_wait[1*W +: W] = wv[1];
    req = 4'b0010;
    tick();
    check("nodone_grant", 64'({grant, tmr_wait}), 64'({4'b0010, 32'd20}));
`ifdef TIMER_WATCHDOG_EN
    for (int k = 0; k < 35; k++) begin
      tick();
      check("wd_hold", 64'({grant, err, done}), 64'({4'b0010, 8'd0}));
    end
    tick();
    check("wd_err", 64'({grant, done, err, tmr_start, busy}), 64'({4'b0000, 4'b0000, 4'b0010, 2'b01}));
    req = '0;
`else
    for (int k = 0; k < 60; k++) begin
      tick();
      check("nowd_hold", 64'({grant, err, done, busy}), 64'({4'b0010, 8'd0, 1'b1}));
    end
    tmr_done = 1'b1;
    tick();
    check("nowd_done", 64'({grant, done, err}), 64'({4'b0000, 4'b0010, 4'b0000}));
    req = '0;
`endif
    tick();
    tick();
    check("nodone_idle", 64'({grant, done, err, busy}), 64'(0));
    ptr_m = 1;

    // Randomized rounds
    for (int n = 0; n < 25; n++) begin
      set = N'($urandom_range(15, 1));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(9, 0);
        if (r == 0)      wv[i] = 32'd0;
        else if (r == 1) wv[i] = MAXW + 32'd1 + 32'($urandom_range(1000, 0));
        else if (r == 2) wv[i] = MAXW;
        else             wv[i] = 32'($urandom_range(50, 1));
      end
      run_round(set, 4'b0000, 1, 5, 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
